// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - operator codes, legality check and sequencer state encoding for the shared ALU
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [5:0] OP_ADD = 6'b011000;
    localparam logic [5:0] OP_SUB = 6'b011001;
    localparam logic [5:0] OP_XOR = 6'b101111;
    localparam logic [5:0] OP_OR  = 6'b101110;
    localparam logic [5:0] OP_AND = 6'b010101;
    localparam logic [5:0] OP_SRA = 6'b100100;
    localparam logic [5:0] OP_SRL = 6'b100101;
    localparam logic [5:0] OP_SLL = 6'b100111;
    localparam logic [5:0] OP_LTS = 6'b000000;
    localparam logic [5:0] OP_LTU = 6'b000001;
    localparam logic [5:0] OP_GES = 6'b001010;
    localparam logic [5:0] OP_GEU = 6'b001011;
    localparam logic [5:0] OP_EQ  = 6'b001100;
    localparam logic [5:0] OP_NE  = 6'b001101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SRA, OP_SRL, OP_SLL,
            OP_LTS, OP_LTU, OP_GES, OP_GEU, OP_EQ, OP_NE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU with comparison flag
module alu
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [5:0]   operator,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res,
    output logic         comp_res
);

    localparam int SH_W = $clog2(W);

    logic [SH_W-1:0] shamt;
    logic            is_cmp;

    assign shamt = b[SH_W-1:0];

    always_comb begin
        res      = '0;
        comp_res = 1'b0;
        is_cmp   = 1'b0;
        case (operator)
            OP_ADD: res = a + b;
            OP_SUB: res = a - b;
            OP_XOR: res = a ^ b;
            OP_OR:  res = a | b;
            OP_AND: res = a & b;
            OP_SRA: res = $signed(a) >>> shamt;
            OP_SRL: res = a >> shamt;
            OP_SLL: res = a << shamt;
            OP_LTS: begin is_cmp = 1'b1; comp_res = $signed(a) <  $signed(b); end
            OP_LTU: begin is_cmp = 1'b1; comp_res = a <  b; end
            OP_GES: begin is_cmp = 1'b1; comp_res = $signed(a) >= $signed(b); end
            OP_GEU: begin is_cmp = 1'b1; comp_res = a >= b; end
            OP_EQ:  begin is_cmp = 1'b1; comp_res = a == b; end
            OP_NE:  begin is_cmp = 1'b1; comp_res = a != b; end
            default: res = '0;
        endcase
        // Compare ops also present the boolean on the result bus.
        if (is_cmp) begin
            res = W'(comp_res);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter and sequencer for the shared ALU
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [5:0]       req_op0,
    input  logic [5:0]       req_op1,
    input  logic [W-1:0]     req_a0,
    input  logic [W-1:0]     req_b0,
    input  logic [W-1:0]     req_a1,
    input  logic [W-1:0]     req_b1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [W-1:0]     rsp_res,
    output logic             rsp_flag,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t       state;
    logic         owner;
    logic         last;
    logic [5:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] alu_res;
    logic         alu_comp;
    logic         grant_any;
    logic         grant;

    alu #(.W(W)) u_alu (
        .operator (op_q),
        .a        (a_q),
        .b        (b_q),
        .res      (alu_res),
        .comp_res (alu_comp)
    );

    // On contention the port that did not finish last wins.
    always_comb begin
        grant_any = |req_valid;
        grant     = (&req_valid) ? ~last : req_valid[1];
        req_ready = '0;
        if (state == ST_IDLE && grant_any) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_valid <= '0;
            rsp_res   <= '0;
            rsp_flag  <= 1'b0;
            rsp_err   <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        owner <= grant;
                        op_q  <= grant ? req_op1 : req_op0;
                        a_q   <= grant ? req_a1  : req_a0;
                        b_q   <= grant ? req_b1  : req_b0;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_legal_op(op_q)) begin
                        rsp_res  <= alu_res;
                        rsp_flag <= alu_comp;
                        rsp_err  <= 1'b0;
                    end else begin
                        rsp_res  <= '0;
                        rsp_flag <= 1'b0;
                        rsp_err  <= 1'b1;
                    end
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        op_count  <= op_count + CNT_W'(1);
                        last      <= owner;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [5:0]  req_op0 = '0, req_op1 = '0;
    logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b11;
    logic [31:0] rsp_res;
    logic        rsp_flag;
    logic        rsp_err;
    logic        busy;
    logic [15:0] op_count;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_cnt = 0;

    alu_arbiter #(.W(32), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op0   (req_op0),
        .req_op1   (req_op1),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_flag  (rsp_flag),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_res"},   rsp_res, 32'd0);
        check({tag, "_rsp_flag"},  32'(rsp_flag), 32'd0);
        check({tag, "_rsp_err"},   32'(rsp_err), 32'd0);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_op_count"},  32'(op_count), 32'd0);
    endtask

    task automatic set_req(input int p, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end
        req_valid[p] = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 2'b11;
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
    endtask

    // Called at a negedge right after the request was raised.
    task automatic wait_grant(input int p);
        int n = 0;
        #1;
        while (req_ready[p] !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("grant", 32'(req_ready), 32'(2'b01 << p));
    endtask

    task automatic do_op(input int p, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ef, input logic ee);
        @(negedge clk);
        set_req(p, op, a, b);
        wait_grant(p);
        @(negedge clk);
        req_valid[p] = 1'b0;
        check("exec_no_rsp", 32'(rsp_valid), 32'd0);
        check("exec_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("rsp_valid", 32'(rsp_valid), 32'(2'b01 << p));
        check("rsp_res", rsp_res, er);
        check("rsp_flag", 32'(rsp_flag), 32'(ef));
        check("rsp_err", 32'(rsp_err), 32'(ee));
        exp_cnt++;
        @(negedge clk);
        check("op_count", 32'(op_count), 32'(exp_cnt));
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Single requester, immediate response consumption.
        do_op(0, OP_ADD, 32'd5, 32'd6, 32'd11, 1'b0, 1'b0);

        // Simultaneous requests after reset: port 0, then port 1, then port 0 again.
        do_reset();
        @(negedge clk);
        set_req(0, OP_SUB, 32'd14, 32'd3);
        set_req(1, OP_SLL, 32'd5, 32'd2);
        #1;
        check("pair1_grant", 32'(req_ready), 32'b01);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("pair1_wait", 32'(req_ready), 32'b00);
        @(negedge clk);
        check("pair1_rsp_valid", 32'(rsp_valid), 32'b01);
        check("pair1_res", rsp_res, 32'd11);
        @(negedge clk);
        #1;
        check("pair2_grant", 32'(req_ready), 32'b10);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("pair2_rsp_valid", 32'(rsp_valid), 32'b10);
        check("pair2_res", rsp_res, 32'd20);
        @(negedge clk);
        set_req(0, OP_SUB, 32'd14, 32'd3);
        set_req(1, OP_SLL, 32'd5, 32'd2);
        #1;
        check("pair3_grant", 32'(req_ready), 32'b01);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("pair3_rsp_valid", 32'(rsp_valid), 32'b01);
        check("pair3_res", rsp_res, 32'd11);
        @(negedge clk);
        check("pair3_count", 32'(op_count), 32'd3);
        exp_cnt = 3;

        // Compare flags and illegal opcode.
        do_op(1, OP_LTS, 32'd5, 32'hFFFF_FFF8, 32'd0, 1'b0, 1'b0);
        do_op(1, OP_GEU, 32'hFFFF_FFF6, 32'd2, 32'd1, 1'b1, 1'b0);
        do_op(0, 6'b111111, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1);
        do_op(0, OP_SRA, 32'h8000_0010, 32'd4, 32'hF800_0001, 1'b0, 1'b0);

        // Backpressure on port 0 while port 1 waits.
        rsp_ready = 2'b00;
        @(negedge clk);
        set_req(0, OP_XOR, 32'd3, 32'd2);
        wait_grant(0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        set_req(1, OP_ADD, 32'd1, 32'd2);
        #1;
        check("bp_exec_ready", 32'(req_ready), 32'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("bp_rsp_valid", 32'(rsp_valid), 32'b01);
            check("bp_res", rsp_res, 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'b00);
        end
        @(negedge clk);
        rsp_ready = 2'b11;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'b00);
        exp_cnt++;
        @(negedge clk);
        #1;
        check("bp_p1_grant", 32'(req_ready), 32'b10);
        check("bp_count", 32'(op_count), 32'(exp_cnt));
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("bp_p1_rsp_valid", 32'(rsp_valid), 32'b10);
        check("bp_p1_res", rsp_res, 32'd3);
        exp_cnt++;
        @(negedge clk);
        check("bp_p1_count", 32'(op_count), 32'(exp_cnt));

        // Reset asserted during EXEC discards the operation.
        @(negedge clk);
        set_req(0, OP_ADD, 32'd7, 32'd8);
        wait_grant(0);
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("rst_in_exec_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_op(1, OP_AND, 32'd12, 32'd10, 32'd8, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
